// File: rtl/prim_ram_1p_adapter.sv
// Valid/ready host adapter for a single-port 1-cycle-latency RAM with an in-order 3-entry response FIFO.
// Optional post-reset init sweep enabled by defining PRIM_RAM_1P_ADAPTER_INIT_EN.
module prim_ram_1p_adapter #(
    parameter int               Width     = 32,
    parameter int               Depth     = 128,
    parameter int               Aw        = $clog2(Depth),
    parameter logic [Width-1:0] InitValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [Aw-1:0]    req_addr_i,
    input  logic [Width-1:0] req_wdata_i,
    input  logic [Width-1:0] req_wmask_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_write_o,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic             ram_rvalid_i,
    input  logic [Width-1:0] ram_rdata_i,
    output logic             init_done_o,
    output logic             err_o
);

    logic run;
    logic host_issue;
    logic pend_q, pend_wr_q;
    logic err_q, err_d;
    logic pend_read;

    logic [Width:0]   mem_q [3];
    logic [1:0]       wptr_q, wptr_d;
    logic [1:0]       rptr_q, rptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             push, pop;
    logic [Width-1:0] push_rdata;
    logic [Width:0]   head;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

`ifdef PRIM_RAM_1P_ADAPTER_INIT_EN
    typedef enum logic {StInit, StRun} state_e;
    state_e        state_q, state_d;
    logic [Aw-1:0] init_cnt_q, init_cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == StInit) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == Aw'(Depth - 1)) state_d = StRun;
        end
    end

    assign run = (state_q == StRun);
`else
    assign run = 1'b1;
`endif

    // Credit counts both queued responses and the request still in flight.
    assign req_ready_o = run & (({1'b0, cnt_q} + {2'b00, pend_q}) < 3'd3);
    assign host_issue  = req_valid_i & req_ready_o;
    assign init_done_o = run;

    always_comb begin
        ram_req_o   = host_issue;
        ram_write_o = req_write_i;
        ram_addr_o  = req_addr_i;
        ram_wdata_o = req_wdata_i;
        ram_wmask_o = req_wmask_i;
`ifdef PRIM_RAM_1P_ADAPTER_INIT_EN
        if (state_q == StInit) begin
            ram_req_o   = 1'b1;
            ram_write_o = 1'b1;
            ram_addr_o  = init_cnt_q;
            ram_wdata_o = InitValue;
            ram_wmask_o = '1;
        end
`endif
    end

    assign pend_read = pend_q & ~pend_wr_q;
    assign err_d     = err_q | (pend_read ^ ram_rvalid_i);
    assign err_o     = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q    <= 1'b0;
            pend_wr_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pend_q    <= host_issue;
            pend_wr_q <= req_write_i;
            err_q     <= err_d;
        end
    end

    // Retire stage: the previous cycle's request lands in the FIFO, even if rvalid was missing.
    assign push       = pend_q;
    assign push_rdata = pend_wr_q ? '0 : ram_rdata_i;
    assign pop        = rsp_valid_o & rsp_ready_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) wptr_d = ptr_inc(wptr_q);
        if (pop)  rptr_d = ptr_inc(rptr_q);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= {pend_wr_q, push_rdata};
    end

    assign head        = mem_q[rptr_q];
    assign rsp_valid_o = (cnt_q != 2'd0);
    assign rsp_write_o = rsp_valid_o & head[Width];
    assign rsp_rdata_o = rsp_valid_o ? head[Width-1:0] : '0;

endmodule

// File: doc/prim_ram_1p_adapter.md
# prim_ram_1p_adapter

Initiator-side adapter that drives a single-port synchronous RAM (the `req/write/addr/wdata/wmask` → `rvalid/rdata` interface, fixed 1-cycle read latency). Host requests arrive on a valid/ready channel. Every request, read or write, returns exactly one in-order response on a valid/ready channel. A 3-entry response FIFO provides backpressure. An optional post-reset sweep zero-initialises the RAM.

## Interface
Parameters:
- `Width`, 32, data width in bits.
- `Depth`, 128, RAM words.
- `Aw`, `$clog2(Depth)`, address width.
- `InitValue`, `'0`, word written by the init sweep.

Ports:
- `clk_i` input 1: single clock.
- `rst_i` input 1: asynchronous, active-high reset.
- `req_valid_i` input 1: host request valid.
- `req_ready_o` output 1: adapter can accept a request.
- `req_write_i` input 1: 1 = write, 0 = read.
- `req_addr_i` input Aw: word address.
- `req_wdata_i` input Width: write data.
- `req_wmask_i` input Width: per-bit write enable.
- `rsp_valid_o` output 1: response valid.
- `rsp_ready_i` input 1: host accepts the response.
- `rsp_write_o` output 1: response is a write acknowledge.
- `rsp_rdata_o` output Width: read data; 0 for write acks.
- `ram_req_o`, `ram_write_o` output 1: RAM request and write strobe.
- `ram_addr_o` output Aw: RAM address.
- `ram_wdata_o`, `ram_wmask_o` output Width: RAM write data and mask.
- `ram_rvalid_i` input 1: RAM read valid.
- `ram_rdata_i` input Width: RAM read data.
- `init_done_o` output 1: RAM is ready for host traffic.
- `err_o` output 1: sticky protocol error.

## Operation
- **Issue.** `ram_req_o = req_valid_i & req_ready_o` (combinational).
  - `ram_write_o`, `ram_addr_o`, `ram_wdata_o` and `ram_wmask_o` pass `req_*` through.
  - Request fields are don't-care when `ram_req_o` = 0.
- **In-flight tracking.** Registers `pend_q` and `pend_wr_q` record the request issued in the previous cycle. At most one request is in flight.
- **Retire.** In the cycle after issue, one entry is pushed into the response FIFO:
  - read: `{write=0, rdata=ram_rdata_i}`;
  - write: `{write=1, rdata=0}`.
  - Ordering is strictly preserved.
- **Credit.** `req_ready_o = RUN && (fifo_count + pend_q) < 3`.
  - Computed from registers only, with no combinational path from `req_valid_i` or `rsp_ready_i`.
- **FIFO.** Depth 3, entries `Width+1` bits. `rsp_valid_o` = FIFO non-empty; the head drives `rsp_write_o` and `rsp_rdata_o`.
  - Pop on `rsp_valid_o & rsp_ready_i`. Push and pop may occur in the same cycle.
  - Overflow cannot occur by construction; the bench asserts this.
- **Error (sticky until reset).** `err_o` sets when either:
  - `pend_q & ~pend_wr_q & ~ram_rvalid_i`, or
  - `ram_rvalid_i & ~(pend_q & ~pend_wr_q)`.
  - Data is still pushed on a missing `ram_rvalid_i`.
- **FSM states.**
  - INIT: present only with the macro; described under Configuration.
  - RUN: normal operation.
  - Reset enters INIT if compiled in, otherwise RUN.

## Timing
- **Reset values:**
  - `req_ready_o` = 0 in INIT, 1 in RUN.
  - `rsp_valid_o`, `rsp_write_o`, `rsp_rdata_o` = 0.
  - `ram_req_o` = 0 in RUN with no valid request.
  - `err_o` = 0.
  - `init_done_o` = 0 with the macro, 1 without it.
- **Latency.** A request accepted in cycle N is issued to the RAM in cycle N, captured at the end of N+1, and appears on `rsp_valid_o` in N+2.
- **Throughput.** One request per cycle is sustained while `rsp_ready_i` is held high.
- **Backpressure.** With `rsp_ready_i` = 0 from idle, exactly 3 requests are accepted, then `req_ready_o` drops. It rises the cycle after the first pop.
- **Mid-operation reset.** Asserting `rst_i` asynchronously clears the FIFO, `pend_q`, `err_o` and the FSM. In-flight responses are discarded. The RAM contents are not guaranteed.

## Configuration
- Macro: `PRIM_RAM_1P_ADAPTER_INIT_EN`.
- **Defined:**
  - After reset the FSM is in INIT. A `Aw`-bit counter writes `InitValue` with full mask to addresses 0…Depth-1, one per cycle, with `ram_req_o` = `ram_write_o` = 1.
  - `req_ready_o` = 0 throughout INIT. Sweep writes produce no responses.
  - After the address-`Depth-1` write, the FSM moves to RUN and `init_done_o` = 1 from the next cycle.
- **Undefined:**
  - No counter or INIT state. Reset goes straight to RUN.
  - `init_done_o` is tied to 1.

## Test plan
- **Single read.** Idle; read addr 0x05, RAM returns 0xDEADBEEF → `ram_req_o` in cycle N; `rsp_valid_o` in N+2 with `rsp_write_o` = 0 and `rsp_rdata_o` = 0xDEADBEEF; `err_o` = 0.
- **Streaming.** 4 back-to-back writes to addr 0–3 (data 0x11…0x44, mask all-ones), then 4 reads of addr 0–3, `rsp_ready_i` = 1 → 8 cycles of continuous acceptance; 4 write acks then read data 0x11, 0x22, 0x33, 0x44 in order.
- **Backpressure.** `rsp_ready_i` = 0 and a continuous read stream → exactly 3 accepted, then `req_ready_o` = 0. Raise `rsp_ready_i` → responses drain in order; `req_ready_o` = 1 the cycle after the first pop.
- **Protocol error.** Inject `ram_rvalid_i` = 1 with nothing pending → `err_o` = 1 next cycle and stays 1 until `rst_i`.
- **Mid-operation reset.** Assert `rst_i` with 2 responses queued and 1 in flight → `rsp_valid_o` = 0 immediately; no stale responses appear after reset.
- **Init sweep (macro defined, Depth = 8).** Release reset → 8 consecutive RAM writes to addr 0–7 of `InitValue`; `init_done_o` and `req_ready_o` rise in the following cycle. A subsequent read of addr 7 returns `InitValue`.
